// File: rtl/imem_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface imem_if #(
  parameter int XLEN = 64
) ();
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per fetch_start over
// the imem request/ack bus with a bounded wait, holds the fetched word for
// decode, and accepts branch/jump redirects. Misaligned fetch addresses and
// memory timeouts raise a sticky fault that only an aligned redirect clears.
module instr_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  imem_if.master          imem,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic            instr_valid,
  output logic            busy,
  output logic            fault,
  output logic [1:0]      fault_code
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_TIMEOUT  = 2'd2
  } fault_code_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  // The wait counter starts at 0 on the first request cycle, so the request
  // is abandoned after TIMEOUT consecutive cycles without an ack.
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            busy_q, busy_d;
  logic            fault_q, fault_d;
  fault_code_t     fault_code_q, fault_code_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  logic [XLEN-1:0] fetch_addr;

  // A redirect arriving with fetch_start is fetched directly instead of the PC.
  assign fetch_addr = redirect_valid ? redirect_pc : pc_q;

  // Next-state and next-output computation for the IDLE/REQ/FAULT machine.
  always_comb begin
    // NOTE: every _d gets a hold default first; a path that leaves one
    // unassigned would otherwise infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    req_d         = req_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    busy_d        = busy_q;
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    cnt_d         = cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_pc_d     = pend_pc_q;

    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (fetch_start) begin
          if (fetch_addr[1:0] != 2'b00) begin
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            fault_code_d = FC_MISALIGN;
          end else begin
            state_d       = S_REQ;
            req_d         = 1'b1;
            addr_d        = fetch_addr;
            instr_valid_d = 1'b0;
            busy_d        = 1'b1;
            cnt_d         = '0;
            pend_valid_d  = 1'b0;
          end
        end
      end

      S_REQ: begin
        // A redirect never cancels the in-flight fetch; it is applied to the
        // PC once the fetch completes, last one wins.
        if (redirect_valid) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_pc;
        end
        if (imem.ack) begin
          state_d       = S_IDLE;
          instr_d       = imem.rdata;
          instr_valid_d = 1'b1;
          req_d         = 1'b0;
          busy_d        = 1'b0;
          pend_valid_d  = 1'b0;
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else if (pend_valid_q) begin
            pc_d = pend_pc_q;
          end else begin
            pc_d = addr_q + XLEN'(4);  // wraps modulo 2^XLEN
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d      = S_FAULT;
          req_d        = 1'b0;
          busy_d       = 1'b0;
          fault_d      = 1'b1;
          fault_code_d = FC_TIMEOUT;
          pend_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_FAULT: begin
        if (redirect_valid && (redirect_pc[1:0] == 2'b00)) begin
          state_d      = S_IDLE;
          pc_d         = redirect_pc;
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any outstanding request at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      addr_q        <= RESET_PC;
      req_q         <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
      cnt_q         <= '0;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      req_q         <= req_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      cnt_q         <= cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_pc_q     <= pend_pc_d;
    end
  end

  assign imem.req    = req_q;
  assign imem.addr   = addr_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;

endmodule
